// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
// Each channel runs its own period counter and shows OFF, ON, BLINK (50%)
// or PWM (programmable duty). Configuration arrives over a valid/ready port
// that accepts at most one request every two cycles. The LED and tick
// outputs are registered and reflect the counter value one cycle earlier.
module led_pattern_gen #(
  parameter int CHANNELS       = 3,
  parameter int CNT_W          = 25,
  parameter int DEFAULT_PERIOD = 24000000,
  parameter bit ACTIVE_LOW     = 1'b1,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  output logic                cfg_err,
  input  logic                resync,
  output logic [CHANNELS-1:0] led_n,
  output logic [CHANNELS-1:0] tick
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_DUTY   = CNT_W'(DEFAULT_PERIOD / 2);

  // Per-channel configuration and counters
  mode_e            mode_q   [CHANNELS];
  logic [CNT_W-1:0] period_q [CHANNELS];
  logic [CNT_W-1:0] duty_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_q    [CNT_W > 0 ? CHANNELS : 1];
  logic [CNT_W-1:0] cnt_d    [CHANNELS];

  // Registered outputs
  logic [CHANNELS-1:0] led_n_q;
  logic [CHANNELS-1:0] tick_q;
  logic                cfg_err_q;
  logic                cfg_ready_q;

  // Combinational helpers
  logic                transfer_s;
  logic                chan_bad_s;
  logic [CNT_W-1:0]    eff_s  [CHANNELS];
  logic [CHANNELS-1:0] wrap_s;
  logic [CHANNELS-1:0] lit_s;
  logic [CHANNELS-1:0] sel_s;

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign led_n     = led_n_q;
  assign tick      = tick_q;

  // Decode the handshake, effective period, wrap point, lit state and next count
  always_comb begin
    transfer_s = cfg_valid && cfg_ready_q;
    chan_bad_s = (32'(cfg_chan) >= 32'(CHANNELS));
    for (int i = 0; i < CHANNELS; i++) begin
      // A zero period behaves like a period of one: the counter parks at 0
      eff_s[i]  = (period_q[i] == {CNT_W{1'b0}}) ? CNT_W'(1) : period_q[i];
      wrap_s[i] = (cnt_q[i] == (eff_s[i] - CNT_W'(1)));
      sel_s[i]  = transfer_s && !chan_bad_s && (cfg_chan == CH_W'(i));
      case (mode_q[i])
        MODE_OFF:   lit_s[i] = 1'b0;
        MODE_ON:    lit_s[i] = 1'b1;
        MODE_BLINK: lit_s[i] = (cnt_q[i] < (eff_s[i] >> 1));
        MODE_PWM:   lit_s[i] = (cnt_q[i] < duty_q[i]);
        default:    lit_s[i] = 1'b0;
      endcase
      if (resync || sel_s[i] || wrap_s[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State and output registers; configuration lands on the target channel only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_BLINK;
        period_q[i] <= DEF_PERIOD;
        duty_q[i]   <= DEF_DUTY;
        cnt_q[i]    <= {CNT_W{1'b0}};
      end
      led_n_q     <= {CHANNELS{ACTIVE_LOW}};
      tick_q      <= {CHANNELS{1'b0}};
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        led_n_q[i] <= lit_s[i] ^ ACTIVE_LOW;
        tick_q[i]  <= wrap_s[i];
        if (sel_s[i]) begin
          mode_q[i]   <= mode_e'(cfg_mode);
          period_q[i] <= cfg_period;
          duty_q[i]   <= cfg_duty;
        end
      end
      cfg_err_q   <= transfer_s && chan_bad_s;
      cfg_ready_q <= !transfer_s;
    end
  end

endmodule
